pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/flush controller driving the stall and flush inputs of the IF/ID and ID/EX
//  pipeline registers and the PC mux. Detects load-use hazards (ID vs EX), taken
//  branch/jump redirects resolved in EX, and data-memory wait stalls. Runs a small FSM
//  that stretches the redirect flush to cover fetch latency, and keeps saturating
//  stall/flush event counters for performance analysis.
// PARAMETERS
//  XLEN          32  PC/target width
//  FLUSH_CYCLES  1   cycles if_id_flush is held after a redirect (>=1; covers imem latency)
//  CNT_W         16  width of each performance counter
// PORTS
//  clk             in   1     clock, all state updates on rising edge
//  reset_n         in   1     asynchronous, active-low reset
//  id_rs1,id_rs2   in   5     source regs of instruction in ID
//  id_uses_rs1/2   in   1     ID instruction actually reads rs1 / rs2
//  ex_rd           in   5     dest reg of instruction in EX (ID/EX output)
//  ex_MemRead      in   1     EX instruction is a load
//  ex_Branch       in   1     EX instruction is a conditional branch
//  ex_branch_taken in   1     branch condition true (EX compare result)
//  ex_Jump         in   1     EX instruction is an unconditional jump
//  ex_target       in   XLEN  redirect target computed in EX
//  mem_req         in   1     MEM stage has a data-memory access in flight
//  mem_ready       in   1     data memory completes access this cycle
//  cnt_clear       in   1     synchronous clear of both perf counters
//  pc_write        out  1     PC may update
//  if_id_write     out  1     IF/ID may load
//  if_id_flush     out  1     IF/ID loads a bubble
//  id_ex_flush     out  1     ID/EX loads a bubble (drives its flush input)
//  pipe_hold       out  1     freeze ID/EX, EX/MEM, MEM/WB (memory stall)
//  pc_sel          out  1     1 = PC takes pc_redirect
//  pc_redirect     out  XLEN  redirect target (= ex_target when pc_sel)
//  stall_cycles    out  CNT_W saturating count of stalled cycles
//  flush_events    out  CNT_W saturating count of redirects
// BEHAVIOUR
//  Terms: load_use = ex_MemRead & ex_rd!=0 & ((id_uses_rs1&id_rs1==ex_rd)|(id_uses_rs2&id_rs2==ex_rd))
//         redirect = (ex_Branch & ex_branch_taken) | ex_Jump;  mem_stall = mem_req & ~mem_ready
//  All control outputs are combinational from state + inputs (zero latency, act on next edge).
//  Priority per cycle: reset > mem_stall > redirect > load_use > normal.
//  reset_n low: state=RUN, flush counter=0, stall_cycles=flush_events=0; outputs forced
//   pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_hold=0, pc_sel=0.
//  pc_redirect = ex_target always (meaningful only when pc_sel=1).
//  FSM states RUN, FLUSH:
//   RUN, normal: pc_write=1, if_id_write=1, all flush/hold/pc_sel=0.
//   any state, mem_stall: pc_write=0, if_id_write=0, pipe_hold=1, flushes=0, pc_sel=0;
//     state and flush counter hold; stall_cycles+1. Redirect/load_use ignored (EX held,
//     re-evaluated when mem_stall drops).
//   redirect (no mem_stall): pc_sel=1, pc_write=1, if_id_flush=1, id_ex_flush=1;
//     flush_events+1; if FLUSH_CYCLES>1 -> FLUSH with counter=FLUSH_CYCLES-1, else stay RUN.
//   load_use (RUN, no redirect): pc_write=0, if_id_write=0, id_ex_flush=1 (one bubble);
//     stall_cycles+1. Redirect same cycle wins; no stall counted.
//   FLUSH: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=0; counter-1; at
//     counter==1 -> RUN. load_use ignored (ID holds a bubble). New redirect in FLUSH
//     restarts the sequence exactly as from RUN.
//  Counters saturate at 2^CNT_W-1; cnt_clear zeroes both, wins over a same-cycle increment.
//  Reset mid-FLUSH or mid-stall: immediate return to reset values, no pending state.
// TESTING
//  1 Reset: hold reset_n=0 3 cycles -> if_id_flush=id_ex_flush=1, pc_write=0, counters 0.
//  2 Load-use: ex_MemRead=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle pc_write=0,
//    id_ex_flush=1; stall_cycles=1; ex_rd=0 same stimulus -> no stall.
//  3 Taken branch, FLUSH_CYCLES=3, ex_target=0x0000_0040 -> pc_sel=1, pc_redirect=0x40,
//    if_id_flush high 3 cycles, id_ex_flush high 1 cycle, flush_events=1.
//  4 Redirect + load_use same cycle -> redirect actions only, stall_cycles unchanged.
//  5 mem_req=1, mem_ready=0 for 4 cycles during FLUSH -> pipe_hold=1 4 cycles,
//    stall_cycles+=4, FLUSH counter frozen then resumes remaining count.
//  6 CNT_W=4: 20 stall cycles -> stall_cycles=15; cnt_clear with increment -> 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline-side signal bundle of the hazard/flush controller
interface pipeline_hazard_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_MemRead;
  logic             ex_Branch;
  logic             ex_branch_taken;
  logic             ex_Jump;
  logic [XLEN-1:0]  ex_target;
  logic             mem_req;
  logic             mem_ready;
  logic             cnt_clear;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pipe_hold;
  logic             pc_sel;
  logic [XLEN-1:0]  pc_redirect;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead, ex_Branch,
           ex_branch_taken, ex_Jump, ex_target, mem_req, mem_ready, cnt_clear,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, pc_sel,
           pc_redirect, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead, ex_Branch,
           ex_branch_taken, ex_Jump, ex_target, mem_req, mem_ready, cnt_clear,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, pc_sel,
           pc_redirect, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use / redirect / memory-wait hazard controller
// with a redirect flush stretcher and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic            load_use, redirect, mem_stall;
  logic            stall_inc, flush_inc;

  assign load_use  = bus.ex_MemRead && (bus.ex_rd != 5'd0) &&
                     ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                      (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
  assign redirect  = (bus.ex_Branch && bus.ex_branch_taken) || bus.ex_Jump;
  assign mem_stall = bus.mem_req && !bus.mem_ready;

  // A load-use bubble only counts when it is actually inserted.
  assign stall_inc = mem_stall || (state == RUN && !redirect && load_use);
  assign flush_inc = !mem_stall && redirect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (mem_stall) begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
    end else if (redirect) begin
      if (FLUSH_CYCLES > 1) begin
        state_nxt     = FLUSH;
        flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
      end else begin
        state_nxt     = RUN;
        flush_cnt_nxt = '0;
      end
    end else if (state == FLUSH) begin
      flush_cnt_nxt = flush_cnt - FC_W'(1);
      if (flush_cnt == FC_W'(1)) state_nxt = RUN;
    end
  end

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.if_id_write = 1'b1;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;
    bus.pipe_hold   = 1'b0;
    bus.pc_sel      = 1'b0;
    if (!reset_n) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (mem_stall) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.pipe_hold   = 1'b1;
    end else if (redirect) begin
      bus.pc_sel      = 1'b1;
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (state == FLUSH) begin
      bus.if_id_flush = 1'b1;
    end else if (load_use) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
  end

  assign bus.pc_redirect = XLEN'(bus.ex_target);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (bus.cnt_clear) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && stall_q != CNT_MAX) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && flush_q != CNT_MAX) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam int XLEN = 32;
  localparam int FC   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int m_rem, m_stall, m_flush;
  logic [XLEN-1:0] tgt;
  logic [5:0] ctl;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, pc_sel}
  assign ctl = {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                bus.id_ex_flush, bus.pipe_hold, bus.pc_sel};

  function automatic bit m_load_use();
    return bus.ex_MemRead && bus.ex_rd != 0 &&
           ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
            (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
  endfunction

  function automatic bit m_redirect();
    return (bus.ex_Branch && bus.ex_branch_taken) || bus.ex_Jump;
  endfunction

  function automatic bit m_mem_stall();
    return bus.mem_req && !bus.mem_ready;
  endfunction

  function automatic logic [5:0] m_ctl();
    if (!reset_n)      return 6'b001100;
    if (m_mem_stall()) return 6'b000010;
    if (m_redirect())  return 6'b111101;
    if (m_rem > 0)     return 6'b111000;
    if (m_load_use())  return 6'b000100;
    return 6'b110000;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic tick();
    bit ms, rd, lu, clr;
    ms  = m_mem_stall();
    rd  = m_redirect();
    lu  = m_load_use();
    clr = bus.cnt_clear;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (clr) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if ((ms || (m_rem == 0 && !rd && lu)) && m_stall < CMAX) m_stall++;
        if (!ms && rd && m_flush < CMAX) m_flush++;
      end
      if (!ms) begin
        if (rd) m_rem = FC - 1;
        else if (m_rem > 0) m_rem--;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.ex_rd = 0; bus.ex_MemRead = 0; bus.ex_Branch = 0; bus.ex_branch_taken = 0;
    bus.ex_Jump = 0; tgt = 0; bus.ex_target = 0; bus.mem_req = 0; bus.mem_ready = 0;
    bus.cnt_clear = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    bus.mem_req = 1; bus.ex_Jump = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctl !== 6'b001100) begin
        n_fails++; $display("FAIL reset_ctl cycle %0d: got %b want 001100", i, ctl);
      end
      n_checks++;
      if (bus.stall_cycles !== 0 || bus.flush_events !== 0) begin
        n_fails++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_events);
      end
      tick();
    end
    idle_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 6'b110000) begin
      n_fails++; $display("FAIL reset_release_ctl: got %b want 110000", ctl);
    end
    tick();
  endtask

  task automatic test_load_use();
    bus.ex_MemRead = 1; bus.ex_rd = 5; bus.id_rs2 = 5; bus.id_uses_rs2 = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 6'b000100) begin
      n_fails++; $display("FAIL load_use_ctl: got %b want 000100", ctl);
    end
    tick();
    bus.ex_MemRead = 0;
    @(negedge clk);
    n_checks++;
    if (bus.stall_cycles !== 1 || ctl !== 6'b110000) begin
      n_fails++; $display("FAIL load_use_count: got %0d ctl %b want 1 ctl 110000", bus.stall_cycles, ctl);
    end
    bus.ex_MemRead = 1; bus.ex_rd = 0; bus.id_rs2 = 0;
    @(negedge clk);
    n_checks++;
    if (ctl !== 6'b110000) begin
      n_fails++; $display("FAIL load_use_x0: got %b want 110000", ctl);
    end
    tick();
    n_checks++;
    if (bus.stall_cycles !== 1) begin
      n_fails++; $display("FAIL load_use_x0_count: got %0d want 1", bus.stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_branch();
    logic [5:0] want [4] = '{6'b111101, 6'b111000, 6'b111000, 6'b110000};
    bus.ex_Branch = 1; bus.ex_branch_taken = 1; bus.ex_target = 32'h0000_0040;
    @(negedge clk);
    n_checks++;
    if (bus.pc_redirect !== 32'h0000_0040) begin
      n_fails++; $display("FAIL branch_target: got %h want 00000040", bus.pc_redirect);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (ctl !== want[i]) begin
        n_fails++; $display("FAIL branch_seq cycle %0d: got %b want %b", i, ctl, want[i]);
      end
      tick();
      idle_inputs();
    end
    n_checks++;
    if (bus.flush_events !== 1) begin
      n_fails++; $display("FAIL branch_count: got %0d want 1", bus.flush_events);
    end
  endtask

  task automatic test_redirect_load_use();
    bus.ex_Jump = 1; bus.ex_MemRead = 1; bus.ex_rd = 7; bus.id_rs1 = 7; bus.id_uses_rs1 = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 6'b111101) begin
      n_fails++; $display("FAIL redir_lu_ctl: got %b want 111101", ctl);
    end
    tick();
    bus.ex_Jump = 0;
    @(negedge clk);
    n_checks++;
    if (bus.stall_cycles !== 1 || bus.flush_events !== 2) begin
      n_fails++; $display("FAIL redir_lu_count: got %0d/%0d want 1/2", bus.stall_cycles, bus.flush_events);
    end
    n_checks++;
    if (ctl !== 6'b111000) begin
      n_fails++; $display("FAIL flush_ignores_lu: got %b want 111000", ctl);
    end
    tick();
    tick();
    idle_inputs();
  endtask

  task automatic test_mem_stall_in_flush();
    bus.ex_Jump = 1;
    tick();
    bus.ex_Jump = 0;
    tick();
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctl !== 6'b000010) begin
        n_fails++; $display("FAIL mem_stall cycle %0d: got %b want 000010", i, ctl);
      end
      tick();
    end
    bus.mem_req = 0;
    @(negedge clk);
    n_checks++;
    if (ctl !== 6'b111000 || bus.stall_cycles !== 5) begin
      n_fails++; $display("FAIL flush_resume: got %b cnt %0d want 111000 cnt 5", ctl, bus.stall_cycles);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (ctl !== 6'b110000) begin
      n_fails++; $display("FAIL flush_done: got %b want 110000", ctl);
    end
  endtask

  task automatic test_saturation();
    bus.cnt_clear = 1;
    tick();
    bus.cnt_clear = 0; bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    n_checks++;
    if (bus.stall_cycles !== 4'd15) begin
      n_fails++; $display("FAIL stall_saturate: got %0d want 15", bus.stall_cycles);
    end
    bus.cnt_clear = 1;
    tick();
    n_checks++;
    if (bus.stall_cycles !== 0 || bus.flush_events !== 0) begin
      n_fails++; $display("FAIL clear_wins: got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_events);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [5:0] want;
    for (int i = 0; i < 800; i++) begin
      bus.id_rs1 = 5'($urandom_range(0, 3)); bus.id_rs2 = 5'($urandom_range(0, 3));
      bus.id_uses_rs1 = 1'($urandom_range(0, 1)); bus.id_uses_rs2 = 1'($urandom_range(0, 1));
      bus.ex_rd = 5'($urandom_range(0, 3)); bus.ex_MemRead = ($urandom_range(0, 99) < 40);
      bus.ex_Branch = ($urandom_range(0, 99) < 15); bus.ex_branch_taken = 1'($urandom_range(0, 1));
      bus.ex_Jump = ($urandom_range(0, 99) < 5);
      tgt = $urandom(); bus.ex_target = tgt;
      bus.mem_req = ($urandom_range(0, 99) < 30); bus.mem_ready = 1'($urandom_range(0, 1));
      bus.cnt_clear = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 2) begin
        reset_n = 1'b0; model_reset();
      end else begin
        reset_n = 1'b1;
      end
      @(negedge clk);
      want = m_ctl();
      n_checks++;
      if (ctl !== want) begin
        n_fails++; $display("FAIL rand_ctl cycle %0d: got %b want %b", i, ctl, want);
      end
      n_checks++;
      if (bus.pc_redirect !== tgt) begin
        n_fails++; $display("FAIL rand_target cycle %0d: got %h want %h", i, bus.pc_redirect, tgt);
      end
      n_checks++;
      if (bus.stall_cycles !== CW'(m_stall) || bus.flush_events !== CW'(m_flush)) begin
        n_fails++; $display("FAIL rand_counters cycle %0d: got %0d/%0d want %0d/%0d",
                            i, bus.stall_cycles, bus.flush_events, m_stall, m_flush);
      end
      tick();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_redirect_load_use();
    test_mem_stall_in_flush();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
